// File: rtl/keypad_auth_controller.sv
// Purpose : keypad entry sequencer. Collects digits, checks them against the
//           stored password on '#' (or programs a new one in set mode), and
//           enforces a timed lockout after MAX_FAIL consecutive failed checks.
// Latency : '#' sampled at edge N -> CHECK for one cycle -> result pulse
//           registered at edge N+1 and high for exactly one cycle.
// Backpressure: none. Keys are strobes; keys arriving in CHECK or LOCKOUT are dropped.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                lock powered; low returns to IDLE (lockout keeps timing)
//   set_mode              high: '#' programs a new password instead of checking
//   key_valid, key_code   key strobe and code (0-9 digit, 10 '*', 11 '#')
//   correct, wrong        one-cycle result pulses of a check (wrong also on set reject)
//   pw_updated            one-cycle pulse when a new password is stored
//   locked                high for exactly LOCK_CYCLES cycles during lockout
//   digit_count           digits in the entry buffer; PW_LEN+1 marks overflow
module keypad_auth_controller #(
  parameter int                  PW_LEN      = 4,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCK_CYCLES = 1000,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW  = 16'h1234
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       set_mode,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       correct,
  output logic       wrong,
  output logic       pw_updated,
  output logic       locked,
  output logic [3:0] digit_count
);

  localparam int BW = 4 * PW_LEN;
  localparam int TW = $clog2(LOCK_CYCLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENTRY   = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [3:0] KEY_STAR   = 4'd10;
  localparam logic [3:0] KEY_HASH   = 4'd11;
  localparam logic [3:0] PW_LEN_C   = 4'(PW_LEN);
  localparam logic [3:0] MAX_FAIL_C = 4'(MAX_FAIL);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

  logic [1:0]    state;
  logic [BW-1:0] entry_buf;
  logic [BW-1:0] stored_pw;
  logic [3:0]    fail_cnt;
  logic [TW-1:0] lock_timer;

  logic          is_digit;
  logic          is_star;
  logic          is_hash;
  logic [BW-1:0] shifted_buf;
  logic [3:0]    fail_inc;
  logic          pw_match;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_star  = key_valid && (key_code == KEY_STAR);
  assign is_hash  = key_valid && (key_code == KEY_HASH);
  assign fail_inc = fail_cnt + 4'd1;

  // A short entry can never match, even if its zero-padded value equals the password.
  assign pw_match = (digit_count == PW_LEN_C) && (entry_buf == stored_pw);

  // New digit enters at the least significant nibble, so the first digit typed
  // ends up most significant once PW_LEN digits are in.
  generate
    if (PW_LEN == 1) begin : g_shift1
      assign shifted_buf = key_code;
    end else begin : g_shiftn
      assign shifted_buf = {entry_buf[BW-5:0], key_code};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      entry_buf   <= '0;
      digit_count <= 4'd0;
      stored_pw   <= DEFAULT_PW;
      fail_cnt    <= 4'd0;
      lock_timer  <= '0;
      correct     <= 1'b0;
      wrong       <= 1'b0;
      pw_updated  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      correct    <= 1'b0;
      wrong      <= 1'b0;
      pw_updated <= 1'b0;

      if (state == S_LOCKOUT) begin
        // Lockout runs to completion regardless of enable; keys are dropped.
        if (lock_timer == '0) begin
          state    <= S_IDLE;
          locked   <= 1'b0;
          fail_cnt <= 4'd0;
        end else begin
          lock_timer <= lock_timer - 1'b1;
        end
      end else if (!enable) begin
        // Power-off abandons any entry (including a pending CHECK) but keeps
        // the password and failure history.
        state       <= S_IDLE;
        entry_buf   <= '0;
        digit_count <= 4'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (is_digit) begin
              entry_buf   <= shifted_buf;
              digit_count <= 4'd1;
              state       <= S_ENTRY;
            end
          end

          S_ENTRY: begin
            if (is_digit) begin
              if (digit_count < PW_LEN_C) begin
                entry_buf   <= shifted_buf;
                digit_count <= digit_count + 4'd1;
              end else begin
                // Overflow: buffer frozen, count parked one past full so the
                // commit is guaranteed to fail.
                digit_count <= PW_LEN_C + 4'd1;
              end
            end else if (is_star) begin
              entry_buf   <= '0;
              digit_count <= 4'd0;
              state       <= S_IDLE;
            end else if (is_hash) begin
              state <= S_CHECK;
            end
          end

          S_CHECK: begin
            entry_buf   <= '0;
            digit_count <= 4'd0;
            state       <= S_IDLE;
            if (set_mode) begin
              if (digit_count == PW_LEN_C) begin
                stored_pw  <= entry_buf;
                pw_updated <= 1'b1;
              end else begin
                wrong <= 1'b1;
              end
            end else if (pw_match) begin
              correct  <= 1'b1;
              fail_cnt <= 4'd0;
            end else begin
              wrong    <= 1'b1;
              fail_cnt <= fail_inc;
              if (fail_inc == MAX_FAIL_C) begin
                // locked rises on the same edge as the final wrong pulse;
                // loading N-1 and leaving at zero gives exactly N locked cycles.
                state      <= S_LOCKOUT;
                locked     <= 1'b1;
                lock_timer <= LOCK_LOAD;
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
